// File: rtl/sprite_pixel_compositor_pkg.sv
// Shared constants and types for the sprite pixel compositor.
// Geometry, key colour and animation state encoding live here.
package sprite_pkg;

    localparam int DATA_WIDTH = 12;
    localparam int ADDR_WIDTH = 17;
    localparam int BG_W       = 320;
    localparam int BG_H       = 240;
    localparam int SPR_W      = 64;
    localparam int SPR_H      = 32;
    localparam int SPR_FRAMES = 8;
    localparam int SPR_BASE   = BG_W * BG_H;
    localparam int FRAME_DIV  = 4;
    localparam int FIDX_W     = $clog2(SPR_FRAMES);
    localparam int DIV_W      = $clog2(FRAME_DIV);

    typedef logic [DATA_WIDTH-1:0] pixel_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [FIDX_W-1:0]     fidx_t;
    typedef logic [DIV_W-1:0]      div_t;

    localparam pixel_t KEY_COLOR  = 12'h0F0;
    localparam fidx_t  LAST_FRAME = FIDX_W'(SPR_FRAMES - 1);
    localparam fidx_t  TURN_FRAME = FIDX_W'(SPR_FRAMES - 2);
    localparam div_t   DIV_LAST   = DIV_W'(FRAME_DIV - 1);

    typedef enum logic {
        FWD = 1'b0,
        BWD = 1'b1
    } anim_state_t;

endpackage

// File: rtl/sprite_pixel_compositor_if.sv
// Dual-port SRAM read bus: two addresses out, two data words back.
// Data follows its address by one clock (registered read).
interface sprite_pixel_compositor_if;
    import sprite_pkg::*;

    addr_t  sram_addr_1;
    addr_t  sram_addr_2;
    pixel_t sram_data_1;
    pixel_t sram_data_2;

    modport master (
        output sram_addr_1,
        output sram_addr_2,
        input  sram_data_1,
        input  sram_data_2
    );

    modport slave (
        input  sram_addr_1,
        input  sram_addr_2,
        output sram_data_1,
        output sram_data_2
    );

endinterface

// File: rtl/sprite_pixel_compositor_anim_ctrl.sv
// Sprite animation sequencer: frame divider plus loop / ping-pong FSM.
// Only moves on frame_tick, so frame_idx is stable across a visible frame.
module sprite_anim_ctrl
    import sprite_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  frame_tick,
    input  logic  anim_en,
    input  logic  anim_mode,
    output fidx_t frame_idx
);

    anim_state_t state_q;
    anim_state_t state_d;
    div_t        div_q;
    div_t        div_d;
    fidx_t       idx_d;

    // State, divider and frame index registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FWD;
            div_q     <= '0;
            frame_idx <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            frame_idx <= idx_d;
        end
    end

    // Divider count and one animation step every FRAME_DIV ticks.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        idx_d   = frame_idx;
        if (frame_tick && anim_en) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                unique case (state_q)
                    FWD: begin
                        if (frame_idx < LAST_FRAME) begin
                            idx_d = frame_idx + 1'b1;
                        end else if (anim_mode) begin
                            idx_d   = TURN_FRAME;
                            state_d = BWD;
                        end else begin
                            idx_d = '0;
                        end
                    end
                    BWD: begin
                        if (!anim_mode) begin
                            idx_d   = frame_idx + 1'b1;
                            state_d = FWD;
                        end else if (frame_idx != '0) begin
                            idx_d = frame_idx - 1'b1;
                        end else begin
                            idx_d   = fidx_t'(1);
                            state_d = FWD;
                        end
                    end
                endcase
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_pixel_compositor.sv
// Background/sprite address generator and chroma-key compositor.
// Coordinates reach rgb_out after a fixed 3-clock latency.
module sprite_pixel_compositor
    import sprite_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       video_on,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       frame_tick,
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    input  logic       anim_en,
    input  logic       anim_mode,
    sprite_pixel_compositor_if.master sram,
    output pixel_t     rgb_out,
    output fidx_t      frame_idx
);

    logic [9:0]  px;
    logic [9:0]  py;
    logic        von1;
    logic        spr1;
    logic        von2;
    logic        spr2;
    logic        in_spr;
    logic [10:0] x11;
    logic [10:0] y11;
    logic [10:0] px11;
    logic [10:0] py11;
    logic [9:0]  dx;
    logic [9:0]  dy;
    addr_t       bg_addr;
    addr_t       spr_addr;

    sprite_anim_ctrl u_anim (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .anim_en    (anim_en),
        .anim_mode  (anim_mode),
        .frame_idx  (frame_idx)
    );

    // Hit test in 11 bits so px+SPR_W never wraps; build both addresses.
    always_comb begin
        x11    = {1'b0, pixel_x};
        y11    = {1'b0, pixel_y};
        px11   = {1'b0, px};
        py11   = {1'b0, py};
        in_spr = (x11 >= px11) && (x11 < px11 + 11'(SPR_W))
              && (y11 >= py11) && (y11 < py11 + 11'(SPR_H));
        dx     = pixel_x - px;
        dy     = pixel_y - py;
        bg_addr = addr_t'(pixel_y[9:1]) * addr_t'(BG_W)
                + addr_t'(pixel_x[9:1]);
        spr_addr = addr_t'(SPR_BASE)
                 + addr_t'(frame_idx) * addr_t'(SPR_W * SPR_H)
                 + addr_t'(dy) * addr_t'(SPR_W)
                 + addr_t'(dx);
    end

    // Sprite position only changes at vertical blanking.
    always_ff @(posedge clk) begin
        if (reset) begin
            px <= '0;
            py <= '0;
        end else if (frame_tick) begin
            px <= pos_x;
            py <= pos_y;
        end
    end

    // Address stage and flag pipeline matching the SRAM read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            sram.sram_addr_1 <= '0;
            sram.sram_addr_2 <= '0;
            von1 <= 1'b0;
            spr1 <= 1'b0;
            von2 <= 1'b0;
            spr2 <= 1'b0;
        end else begin
            sram.sram_addr_1 <= bg_addr;
            sram.sram_addr_2 <= in_spr ? spr_addr : addr_t'(SPR_BASE);
            von1 <= video_on;
            spr1 <= in_spr;
            von2 <= von1;
            spr2 <= spr1;
        end
    end

    // Chroma-key composite; blank outside the visible area.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_out <= '0;
        end else if (!von2) begin
            rgb_out <= '0;
        end else if (spr2 && sram.sram_data_2 != KEY_COLOR) begin
            rgb_out <= sram.sram_data_2;
        end else begin
            rgb_out <= sram.sram_data_1;
        end
    end

endmodule

// File: tb/tb_sprite_pixel_compositor.sv
// Self-checking bench for sprite_pixel_compositor.
// Model SRAM plus a scoreboard queue of expected pixels.
module tb_sprite_pixel_compositor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        video_on = 1'b0;
    logic [9:0]  pixel_x = '0;
    logic [9:0]  pixel_y = '0;
    logic        frame_tick = 1'b0;
    logic [9:0]  pos_x = '0;
    logic [9:0]  pos_y = '0;
    logic        anim_en = 1'b0;
    logic        anim_mode = 1'b0;
    logic [11:0] rgb_out;
    logic [2:0]  frame_idx;

    int n_checks = 0;
    int n_fail = 0;

    int m_px = 0;
    int m_py = 0;
    int m_fidx = 0;

    logic [11:0] ovr [int];
    logic [11:0] sb [$];

    sprite_pixel_compositor_if sram_bus ();

    sprite_pixel_compositor dut (
        .clk        (clk),
        .reset      (reset),
        .video_on   (video_on),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .frame_tick (frame_tick),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .anim_en    (anim_en),
        .anim_mode  (anim_mode),
        .sram       (sram_bus),
        .rgb_out    (rgb_out),
        .frame_idx  (frame_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] ram(int a);
        logic [11:0] v;
        if (ovr.exists(a)) return ovr[a];
        v = 12'((a * 37 + 11) ^ (a >> 5));
        if (v == 12'h0F0) v = 12'h0F1;
        return v;
    endfunction

    always @(posedge clk) begin
        sram_bus.sram_data_1 <= ram(int'(sram_bus.sram_addr_1));
        sram_bus.sram_data_2 <= ram(int'(sram_bus.sram_addr_2));
    end

    function automatic bit in_box(int x, int y);
        return x >= m_px && x < m_px + 64 && y >= m_py && y < m_py + 32;
    endfunction

    function automatic int exp_a2(int x, int y);
        if (!in_box(x, y)) return 76800;
        return 76800 + m_fidx * 2048 + (y - m_py) * 64 + (x - m_px);
    endfunction

    function automatic logic [11:0] exp_pix(int x, int y, bit von);
        logic [11:0] s;
        if (!von) return 12'h000;
        if (in_box(x, y)) begin
            s = ram(exp_a2(x, y));
            if (s != 12'h0F0) return s;
        end
        return ram((y / 2) * 320 + x / 2);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_px = 0;
        m_py = 0;
        m_fidx = 0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (sram_bus.sram_addr_1 !== 17'd0 || sram_bus.sram_addr_2 !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_addr: got %0d/%0d want 0/0",
                     sram_bus.sram_addr_1, sram_bus.sram_addr_2);
        end
        n_checks++;
        if (rgb_out !== 12'h000 || frame_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_out: got rgb=%h idx=%0d want 000/0",
                     rgb_out, frame_idx);
        end
        reset = 1'b0;
    endtask

    task automatic test_background();
        int xs[6] = '{10, 11, 0, 639, 320, 200};
        int ys[6] = '{6, 6, 0, 479, 240, 17};
        logic [11:0] e;
        for (int i = 0; i < 8; i++) begin
            if (i < 6) begin
                video_on = 1'b1;
                pixel_x = 10'(xs[i]);
                pixel_y = 10'(ys[i]);
                sb.push_back(exp_pix(xs[i], ys[i], 1'b1));
            end
            @(posedge clk); #1;
            if (i == 0) begin
                n_checks++;
                if (sram_bus.sram_addr_1 !== 17'd965) begin
                    n_fail++;
                    $display("FAIL bg_addr1: got %0d want 965",
                             sram_bus.sram_addr_1);
                end
            end
            if (i >= 2) begin
                e = sb.pop_front();
                n_checks++;
                if (rgb_out !== e) begin
                    n_fail++;
                    $display("FAIL bg_rgb[%0d]: got %h want %h", i - 2, rgb_out, e);
                end
            end
        end
    endtask

    task automatic test_sprite(input logic [11:0] spr_val);
        int xs[5] = '{101, 99, 163, 164, 130};
        int ys[5] = '{52, 52, 81, 52, 82};
        logic [11:0] e;
        ovr[76929] = spr_val;
        for (int i = 0; i < 7; i++) begin
            if (i < 5) begin
                video_on = 1'b1;
                pixel_x = 10'(xs[i]);
                pixel_y = 10'(ys[i]);
                sb.push_back(exp_pix(xs[i], ys[i], 1'b1));
            end
            @(posedge clk); #1;
            if (i == 0) begin
                n_checks++;
                if (sram_bus.sram_addr_2 !== 17'd76929) begin
                    n_fail++;
                    $display("FAIL spr_addr2: got %0d want 76929",
                             sram_bus.sram_addr_2);
                end
            end
            if (i >= 2) begin
                e = sb.pop_front();
                if (i == 2) begin
                    e = (spr_val == 12'h0F0) ? ram(26 * 320 + 50) : spr_val;
                end
                n_checks++;
                if (rgb_out !== e) begin
                    n_fail++;
                    $display("FAIL spr_rgb[%0d]: got %h want %h", i - 2, rgb_out, e);
                end
            end
        end
    endtask

    task automatic test_blanking();
        int xs[4] = '{700, 101, 0, 300};
        int ys[4] = '{10, 52, 0, 500};
        bit vs[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [11:0] e;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                video_on = vs[i];
                pixel_x = 10'(xs[i]);
                pixel_y = 10'(ys[i]);
                sb.push_back(exp_pix(xs[i], ys[i], vs[i]));
            end
            @(posedge clk); #1;
            if (i >= 2) begin
                e = sb.pop_front();
                n_checks++;
                if (rgb_out !== e) begin
                    n_fail++;
                    $display("FAIL blank_rgb[%0d]: got %h want %h", i - 2, rgb_out, e);
                end
            end
        end
        video_on = 1'b1;
    endtask

    task automatic test_pos_latch();
        int xs[5] = '{101, 639, 599, 600, 620};
        int ys[5] = '{52, 60, 60, 50, 81};
        logic [11:0] e;
        int a2;
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 0) begin
                pos_x = 10'd300;
                pos_y = 10'd200;
            end else begin
                pos_x = 10'd600;
                pos_y = 10'd50;
                tick();
                m_px = 600;
                m_py = 50;
            end
            for (int i = 0; i < 7; i++) begin
                if (i < 5) begin
                    video_on = 1'b1;
                    pixel_x = 10'(xs[i]);
                    pixel_y = 10'(ys[i]);
                    sb.push_back(exp_pix(xs[i], ys[i], 1'b1));
                end
                @(posedge clk); #1;
                if (i < 5) begin
                    a2 = exp_a2(xs[i], ys[i]);
                    n_checks++;
                    if (sram_bus.sram_addr_2 !== 17'(a2)) begin
                        n_fail++;
                        $display("FAIL pos_addr2[%0d.%0d]: got %0d want %0d",
                                 ph, i, sram_bus.sram_addr_2, a2);
                    end
                end
                if (i >= 2) begin
                    e = sb.pop_front();
                    n_checks++;
                    if (rgb_out !== e) begin
                        n_fail++;
                        $display("FAIL pos_rgb[%0d.%0d]: got %h want %h",
                                 ph, i - 2, rgb_out, e);
                    end
                end
            end
        end
    endtask

    task automatic test_anim_loop();
        do_reset();
        anim_en = 1'b1;
        anim_mode = 1'b0;
        for (int t = 1; t <= 32; t++) begin
            tick();
            n_checks++;
            if (frame_idx !== 3'((t / 4) % 8)) begin
                n_fail++;
                $display("FAIL loop_idx[tick %0d]: got %0d want %0d",
                         t, frame_idx, (t / 4) % 8);
            end
        end
    endtask

    task automatic test_anim_hold();
        do_reset();
        anim_en = 1'b1;
        anim_mode = 1'b0;
        repeat (6) tick();
        anim_en = 1'b0;
        repeat (8) tick();
        n_checks++;
        if (frame_idx !== 3'd1) begin
            n_fail++;
            $display("FAIL hold_idx: got %0d want 1", frame_idx);
        end
        anim_en = 1'b1;
        tick();
        n_checks++;
        if (frame_idx !== 3'd1) begin
            n_fail++;
            $display("FAIL hold_div3: got %0d want 1", frame_idx);
        end
        tick();
        n_checks++;
        if (frame_idx !== 3'd2) begin
            n_fail++;
            $display("FAIL hold_resume: got %0d want 2", frame_idx);
        end
    endtask

    task automatic test_pingpong();
        int seq[15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
        do_reset();
        anim_en = 1'b1;
        anim_mode = 1'b1;
        for (int s = 0; s < 15; s++) begin
            repeat (4) tick();
            n_checks++;
            if (frame_idx !== 3'(seq[s])) begin
                n_fail++;
                $display("FAIL pp_idx[step %0d]: got %0d want %0d",
                         s + 1, frame_idx, seq[s]);
            end
        end
    endtask

    task automatic test_mode_switch();
        do_reset();
        anim_en = 1'b1;
        anim_mode = 1'b1;
        repeat (32) tick();
        n_checks++;
        if (frame_idx !== 3'd6) begin
            n_fail++;
            $display("FAIL sw_bwd: got %0d want 6", frame_idx);
        end
        anim_mode = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (frame_idx !== 3'd7) begin
            n_fail++;
            $display("FAIL sw_fwd: got %0d want 7", frame_idx);
        end
        repeat (4) tick();
        n_checks++;
        if (frame_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL sw_wrap: got %0d want 0", frame_idx);
        end
    endtask

    task automatic test_reset_tick();
        do_reset();
        anim_en = 1'b1;
        anim_mode = 1'b1;
        repeat (7) tick();
        reset = 1'b1;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        frame_tick = 1'b0;
        n_checks++;
        if (frame_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL rt_idx: got %0d want 0", frame_idx);
        end
        repeat (3) tick();
        n_checks++;
        if (frame_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL rt_div: got %0d want 0", frame_idx);
        end
        tick();
        n_checks++;
        if (frame_idx !== 3'd1) begin
            n_fail++;
            $display("FAIL rt_step: got %0d want 1", frame_idx);
        end
    endtask

    initial begin
        test_reset();
        test_background();
        pos_x = 10'd100;
        pos_y = 10'd50;
        tick();
        m_px = 100;
        m_py = 50;
        test_sprite(12'hF00);
        test_sprite(12'h0F0);
        test_blanking();
        test_pos_latch();
        test_anim_loop();
        test_anim_hold();
        test_pingpong();
        test_mode_switch();
        test_reset_tick();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
